// File: rtl/multiword_add_ctrl_pkg.sv
// multiword_add_ctrl_pkg: shared state encodings and default sizing for the multiword adder
package multiword_add_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int N_DEF = 4;
  localparam int K_DEF = 4;
endpackage

// File: rtl/multiword_add_ctrl_cla.sv
// Carry_Look_Ahead_Adder_n_bit: N-bit adder built from generate/propagate terms
module Carry_Look_Ahead_Adder_n_bit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  assign g = a & b;
  assign p = a ^ b;
  // each carry is the generate of its bit or the propagated carry below it
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < N; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end
  assign sum  = p ^ c[N-1:0];
  assign cout = c[N];
endmodule

// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: adds two N*K-bit operands one N-bit word per cycle through a shared adder
module multiword_add_ctrl
  import multiword_add_ctrl_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           cin,
  output logic           busy,
  output logic           done,
  output logic [N*K-1:0] sum,
  output logic           cout
);
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  state_t         state;
  state_t         state_nxt;
  logic [IW-1:0]  idx;
  logic           carry;
  logic [N*K-1:0] a_r;
  logic [N*K-1:0] b_r;
  logic [N-1:0]   add_sum;
  logic           add_cout;
  logic           last;
  assign last = (idx == IW'(K - 1));
  assign busy = (state != IDLE);
  assign done = (state == DONE);
  Carry_Look_Ahead_Adder_n_bit #(.N(N)) u_add (
    .a    (a_r[idx*N +: N]),
    .b    (b_r[idx*N +: N]),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );
  // next state: accept start in IDLE, run K words, then a single DONE cycle
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (start ? RUN : IDLE) :
                (state == RUN)  ? (last ? DONE : RUN) : IDLE;
  end
  // state register plus operand capture and per-word result/carry update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        a_r   <= a;
        b_r   <= b;
        carry <= cin;
        idx   <= '0;
        sum   <= '0;
        cout  <= 1'b0;
      end else if (state == RUN) begin
        sum[idx*N +: N] <= add_sum;
        carry           <= add_cout;
        if (!last) idx <= idx + IW'(1);
        if (last) cout <= add_cout;
      end
    end
  end
endmodule
